// File: rtl/sw_alloc_ctrl_pkg.sv
// Shared sizes, port names and index helpers for the switch allocator.
// Optional starvation guard is enabled by SW_ALLOC_STARVE_GUARD_EN.
package sw_alloc_ctrl_pkg;

    localparam int NUM_PORT     = 5;
    localparam int SEL_W        = 3;
    localparam int STARVE_LIMIT = 15;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [SEL_W-1:0] {
        X0    = 3'd0,
        X1    = 3'd1,
        Y0    = 3'd2,
        Y1    = 3'd3,
        LOCAL = 3'd4
    } port_idx_e;

    typedef logic [NUM_PORT-1:0] port_vec_t;
    typedef logic [SEL_W-1:0]    sel_t;

    function automatic sel_t onehot_to_idx(input port_vec_t oh);
        sel_t idx;
        idx = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (oh[i]) idx = idx | sel_t'(i);
        end
        return idx;
    endfunction

    function automatic port_vec_t lowest_bit(input port_vec_t v);
        return v & (~v + port_vec_t'(1));
    endfunction

    function automatic sel_t wrap_idx(input sel_t base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_PORT) s = s - NUM_PORT;
        return sel_t'(s);
    endfunction

endpackage

// File: rtl/sw_alloc_ctrl_rr_arb.sv
// Per-output round-robin arbiter with wormhole lock mask and priority override.
// Grant is suppressed entirely when the downstream is not ready.
module sw_alloc_ctrl_rr_arb
    import sw_alloc_ctrl_pkg::*;
(
    input  logic [NUM_PORT-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                lock,
    input  logic [SEL_W-1:0]    owner,
    input  logic [NUM_PORT-1:0] pri,
    input  logic                rdy,
    output logic [NUM_PORT-1:0] gnt
);

    port_vec_t cand;
    port_vec_t hot;

    assign hot = req & pri;

    always_comb begin
        cand = '0;
        if (lock) begin
            cand[owner] = req[owner];
        end else if (|hot) begin
            cand = lowest_bit(hot);
        end else begin
            // scan downward so the nearest requester after ptr wins last
            for (int k = NUM_PORT - 1; k >= 0; k--) begin
                if (req[wrap_idx(ptr, k)]) begin
                    cand = '0;
                    cand[wrap_idx(ptr, k)] = 1'b1;
                end
            end
        end
    end

    assign gnt = rdy ? cand : '0;

endmodule

// File: rtl/sw_alloc_ctrl.sv
// Router switch allocator: per-input output choice, per-output round-robin, wormhole locks.
// Define SW_ALLOC_STARVE_GUARD_EN to add per-input starvation priority.
module sw_alloc_ctrl
    import sw_alloc_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORT-1:0]          req_vld,
    input  logic [NUM_PORT*NUM_PORT-1:0] req_prod,
    input  logic [NUM_PORT-1:0]          req_tail,
    input  logic [NUM_PORT-1:0]          out_rdy,
    output logic [NUM_PORT-1:0]          in_gnt,
    output logic [NUM_PORT*NUM_PORT-1:0] in_gnt_port,
    output logic [NUM_PORT*SEL_W-1:0]    xbar_sel,
    output logic [NUM_PORT-1:0]          out_vld,
    output logic [NUM_PORT-1:0]          out_lock
);

    port_vec_t lock;
    sel_t      owner  [NUM_PORT];
    sel_t      rr_ptr [NUM_PORT];

    port_vec_t ireq   [NUM_PORT];
    port_vec_t oreq   [NUM_PORT];
    port_vec_t ogrant [NUM_PORT];
    sel_t      win    [NUM_PORT];
    port_vec_t pri;

    for (genvar i = 0; i < NUM_PORT; i++) begin : g_in
        port_vec_t prod;
        port_vec_t own;
        port_vec_t open;
        port_vec_t pick;

        assign prod = req_prod[i*NUM_PORT +: NUM_PORT];
        assign open = prod & ~lock & out_rdy;

        for (genvar o = 0; o < NUM_PORT; o++) begin : g_own
            assign own[o] = lock[o] && (owner[o] == sel_t'(i));
        end

        // a starved choice still requests so it keeps losing visibly
        always_comb begin
            pick = '0;
            if (rst_n && req_vld[i]) begin
                if (|own) pick = lowest_bit(own);
                else if (|open) pick = lowest_bit(open);
                else pick = lowest_bit(prod);
            end
        end

        assign ireq[i] = pick;

        for (genvar o = 0; o < NUM_PORT; o++) begin : g_xp
            assign oreq[o][i] = ireq[i][o];
            assign in_gnt_port[i*NUM_PORT + o] = ogrant[o][i];
        end

        assign in_gnt[i] = |in_gnt_port[i*NUM_PORT +: NUM_PORT];
    end

    for (genvar o = 0; o < NUM_PORT; o++) begin : g_out
        sw_alloc_ctrl_rr_arb u_arb (
            .req   (oreq[o]),
            .ptr   (rr_ptr[o]),
            .lock  (lock[o]),
            .owner (owner[o]),
            .pri   (pri),
            .rdy   (out_rdy[o]),
            .gnt   (ogrant[o])
        );

        assign win[o]                      = onehot_to_idx(ogrant[o]);
        assign out_vld[o]                  = |ogrant[o];
        assign xbar_sel[o*SEL_W +: SEL_W]  = win[o];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock <= '0;
            for (int o = 0; o < NUM_PORT; o++) begin
                owner[o]  <= '0;
                rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (out_vld[o]) begin
                    rr_ptr[o] <= (win[o] == sel_t'(NUM_PORT - 1)) ?
                                 '0 : win[o] + sel_t'(1);
                    lock[o]   <= ~req_tail[win[o]];
                    if (!req_tail[win[o]]) owner[o] <= win[o];
                end
            end
        end
    end

    assign out_lock = lock;

`ifdef SW_ALLOC_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve [NUM_PORT];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORT; i++) begin
            if (!rst_n || !req_vld[i] || in_gnt[i]) begin
                starve[i] <= '0;
            end else if (starve[i] != STARVE_W'(STARVE_LIMIT)) begin
                starve[i] <= starve[i] + STARVE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_PORT; i++) begin : g_pri
        assign pri[i] = (starve[i] == STARVE_W'(STARVE_LIMIT));
    end
`else
    assign pri = '0;
`endif

endmodule

// File: tb/tb_sw_alloc_ctrl.sv
// Scoreboard bench for sw_alloc_ctrl: expected grants queued at drive time,
// popped and compared on the falling edge.
module tb_sw_alloc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_vld;
    logic [24:0] req_prod;
    logic [4:0]  req_tail;
    logic [4:0]  out_rdy;
    logic [4:0]  in_gnt;
    logic [24:0] in_gnt_port;
    logic [14:0] xbar_sel;
    logic [4:0]  out_vld;
    logic [4:0]  out_lock;

    typedef struct {
        string       tag;
        logic [4:0]  gnt;
        logic [4:0]  vld;
        logic [14:0] sel;
        logic [4:0]  lck;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    sw_alloc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_prod    (req_prod),
        .req_tail    (req_tail),
        .out_rdy     (out_rdy),
        .in_gnt      (in_gnt),
        .in_gnt_port (in_gnt_port),
        .xbar_sel    (xbar_sel),
        .out_vld     (out_vld),
        .out_lock    (out_lock)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] pv(input int i, input logic [4:0] v);
        logic [24:0] r;
        r = '0;
        r[i*5 +: 5] = v;
        return r;
    endfunction

    function automatic logic [14:0] ps(input int o, input int w);
        logic [14:0] r;
        r = '0;
        r[o*3 +: 3] = 3'(w);
        return r;
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            logic [14:0] msk;
            logic [24:0] gp;
            logic [2:0]  w;
            cur = sb.pop_front();
            msk = '0;
            gp  = '0;
            for (int o = 0; o < 5; o++) begin
                if (cur.vld[o]) begin
                    msk[o*3 +: 3] = 3'b111;
                    w = cur.sel[o*3 +: 3];
                    gp[int'(w)*5 + o] = 1'b1;
                end
            end
            check_eq({cur.tag, ":in_gnt"},   32'(in_gnt),          32'(cur.gnt));
            check_eq({cur.tag, ":out_vld"},  32'(out_vld),         32'(cur.vld));
            check_eq({cur.tag, ":xbar_sel"}, 32'(xbar_sel & msk),  32'(cur.sel));
            check_eq({cur.tag, ":gnt_port"}, 32'(in_gnt_port),     32'(gp));
            check_eq({cur.tag, ":out_lock"}, 32'(out_lock),        32'(cur.lck));
        end
    end

    task automatic step(input string tag, input logic [4:0] vld,
                        input logic [24:0] prod, input logic [4:0] tail,
                        input logic [4:0] rdy, input logic [4:0] e_gnt,
                        input logic [4:0] e_vld, input logic [14:0] e_sel,
                        input logic [4:0] e_lck);
        exp_t e;
        req_vld  = vld;
        req_prod = prod;
        req_tail = tail;
        out_rdy  = rdy;
        e.tag = tag;
        e.gnt = e_gnt;
        e.vld = e_vld;
        e.sel = e_sel;
        e.lck = e_lck;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic [24:0] all_local, p3, pw, pr, pm;

    initial begin
        rst_n    = 1'b0;
        req_vld  = '0;
        req_prod = '0;
        req_tail = '0;
        out_rdy  = '0;
        all_local = pv(0, 5'b10000) | pv(1, 5'b10000) | pv(2, 5'b10000) |
                    pv(3, 5'b10000) | pv(4, 5'b10000);
        p3 = pv(0, 5'b10000) | pv(1, 5'b10000) | pv(2, 5'b10000);
        pw = pv(1, 5'b00100) | pv(3, 5'b00100);
        pr = pv(2, 5'b01000) | pv(4, 5'b01000);
        pm = pv(0, 5'b00010) | pv(3, 5'b00010) | pv(4, 5'b00010);
        repeat (2) @(posedge clk);
        #1;

        step("rst", 5'h1F, all_local, 5'h1F, 5'h1F, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("idle",   5'b00000, '0, 5'b00000, 5'h1F, 0, 0, 0, 0);
        step("noprod", 5'b00010, '0, 5'b00010, 5'h1F, 0, 0, 0, 0);

        step("rr0", 5'b00111, p3, 5'h1F, 5'h1F, 5'b00001, 5'b10000, ps(4, 0), 0);
        step("rr1", 5'b00111, p3, 5'h1F, 5'h1F, 5'b00010, 5'b10000, ps(4, 1), 0);
        step("rr2", 5'b00111, p3, 5'h1F, 5'h1F, 5'b00100, 5'b10000, ps(4, 2), 0);
        step("ptr4", 5'b10001, pv(0, 5'b10000) | pv(4, 5'b10000), 5'h1F, 5'h1F,
             5'b10000, 5'b10000, ps(4, 4), 0);

        step("wh_head", 5'b01010, pw, 5'b01000, 5'h1F,
             5'b00010, 5'b00100, ps(2, 1), 5'b00000);
        step("wh_body", 5'b01010, pw, 5'b01000, 5'h1F,
             5'b00010, 5'b00100, ps(2, 1), 5'b00100);
        step("wh_tail", 5'b01010, pw, 5'b01010, 5'h1F,
             5'b00010, 5'b00100, ps(2, 1), 5'b00100);
        step("wh_next", 5'b01000, pw, 5'b01000, 5'h1F,
             5'b01000, 5'b00100, ps(2, 3), 5'b00000);

        step("lk_head", 5'b00100, pv(2, 5'b00001), 5'b00000, 5'h1F,
             5'b00100, 5'b00001, ps(0, 2), 5'b00000);
        step("lk_alt", 5'b00101, pv(2, 5'b00001) | pv(0, 5'b00101), 5'b00001,
             5'h1F, 5'b00101, 5'b00101, ps(0, 2) | ps(2, 0), 5'b00001);
        step("lk_tail", 5'b00100, pv(2, 5'b00001), 5'b00100, 5'h1F,
             5'b00100, 5'b00001, ps(0, 2), 5'b00001);

        for (int c = 0; c < 4; c++)
            step("nordy", 5'b10100, pr, 5'h1F, 5'b10111, 0, 0, 0, 0);
        step("rdy_up", 5'b10100, pr, 5'h1F, 5'h1F,
             5'b00100, 5'b01000, ps(3, 2), 0);

        step("mp_head", 5'b01000, pv(3, 5'b00010), 5'b00000, 5'h1F,
             5'b01000, 5'b00010, ps(1, 3), 5'b00000);
        step("mp_body", 5'b01000, pv(3, 5'b00010), 5'b00000, 5'h1F,
             5'b01000, 5'b00010, ps(1, 3), 5'b00010);
        rst_n = 1'b0;
        step("mp_rst", 5'b01000, pv(3, 5'b00010), 5'b00000, 5'h1F,
             0, 0, 0, 5'b00010);
        rst_n = 1'b1;
        step("mp_fresh", 5'b11001, pm, 5'h1F, 5'h1F,
             5'b00001, 5'b00010, ps(1, 0), 5'b00000);

        @(negedge clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
